// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Word/lane geometry, capture entry layout, default result windows.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    localparam logic [31:0] DFT_WIN_BASE     = 32'h400;
    localparam int          DFT_WIN_WORDS    = 12;
    localparam logic [31:0] ENERGY_WIN_BASE  = 32'h500;
    localparam int          ENERGY_WIN_WORDS = 12;

    // Index field sized for the default result windows.
    localparam int CAP_IDX_W = $clog2(DFT_WIN_WORDS);

    typedef struct packed {
        logic [CAP_IDX_W-1:0] index;
        logic [WORD_W-1:0]    data;
    } cap_entry_t;

    // Per-lane merge of new write data over the old word.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [LANES-1:0]  wen
    );
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int k = 0; k < LANES; k++) begin
            if (wen[k]) begin
                r[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO for captured window writes.
// Ports: push/push_data/full, pop/pop_data/empty; sync active-low reset.
module capture_fifo
    import dmem_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] store_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));

    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

    // Storage is not reset, so mask the head while empty.
    assign pop_data = empty ? '0 : store_q[rd_ptr_q];

endmodule

// File: rtl/dmem_capture_responder.sv
// CPU data-memory responder: byte-writable RAM plus capture of writes
// into a result window, streamed out over cap_valid/cap_ready.
module dmem_capture_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] WIN_BASE   = DFT_WIN_BASE,
    parameter int          WIN_WORDS  = DFT_WIN_WORDS,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  d_mem_addr,
    input  logic [31:0]                  d_mem_wdata,
    input  logic [3:0]                   d_mem_wen,
    output logic [31:0]                  d_mem_rdata,
    output logic                         cap_valid,
    input  logic                         cap_ready,
    output logic [$clog2(WIN_WORDS)-1:0] cap_index,
    output logic [31:0]                  cap_data,
    output logic                         cap_overflow,
    output logic [CNT_W-1:0]             cap_dropped
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam int          IDX_W   = $clog2(WIN_WORDS);
    localparam logic [31:0] MEM_LIM = 32'(4 * MEM_WORDS);
    localparam logic [31:0] WIN_LIM = WIN_BASE + 32'(4 * WIN_WORDS);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [AW-1:0]    widx;
    logic [29:0]      widx_full;
    logic             in_range, in_win;
    logic             wr_en, cap_push;
    logic [31:0]      old_word, word_d;
    cap_entry_t       push_e, head_e;
    logic             fifo_full, fifo_empty, drop;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    assign widx_full = d_mem_addr[31:2];
    assign widx      = widx_full[AW-1:0];
    assign in_range  = d_mem_addr < MEM_LIM;
    assign in_win    = (d_mem_addr >= WIN_BASE) && (d_mem_addr < WIN_LIM);

    assign old_word    = mem_q[widx];
    assign d_mem_rdata = in_range ? old_word : 32'h0;
    assign word_d      = lane_merge(old_word, d_mem_wdata, d_mem_wen);

    // Nothing is written or captured on a reset edge.
    assign wr_en    = rst_n & in_range & (|d_mem_wen);
    assign cap_push = wr_en & in_win;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[widx] <= word_d;
        end
    end

    always_comb begin
        push_e       = '0;
        push_e.index = CAP_IDX_W'(widx_full - 30'(WIN_BASE >> 2));
        push_e.data  = word_d;
    end

    capture_fifo #(
        .WIDTH ($bits(cap_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_push),
        .push_data (push_e),
        .full      (fifo_full),
        .pop       (cap_ready),
        .pop_data  (head_e),
        .empty     (fifo_empty)
    );

    assign cap_valid = ~fifo_empty;
    assign cap_index = IDX_W'(head_e.index);
    assign cap_data  = head_e.data;

    // Dropped only when full and the head is not leaving this edge.
    assign drop = cap_push & fifo_full & ~(cap_ready & cap_valid);

    always_comb begin
        overflow_d = overflow_q | drop;
        dropped_d  = dropped_q;
        if (drop && (dropped_q != '1)) begin
            dropped_d = dropped_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    assign cap_overflow = overflow_q;
    assign cap_dropped  = dropped_q;

endmodule

// File: tb/tb_dmem_capture_responder.sv
// Directed bench for dmem_capture_responder.
// Inputs change and outputs are checked on the falling edge.
module tb_dmem_capture_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;
    logic        cap_valid;
    logic        cap_ready;
    logic [3:0]  cap_index;
    logic [31:0] cap_data;
    logic        cap_overflow;
    logic [15:0] cap_dropped;

    int checks = 0;
    int errors = 0;

    dmem_capture_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_mem_addr   (d_mem_addr),
        .d_mem_wdata  (d_mem_wdata),
        .d_mem_wen    (d_mem_wen),
        .d_mem_rdata  (d_mem_rdata),
        .cap_valid    (cap_valid),
        .cap_ready    (cap_ready),
        .cap_index    (cap_index),
        .cap_data     (cap_data),
        .cap_overflow (cap_overflow),
        .cap_dropped  (cap_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  w);
        @(negedge clk);
        d_mem_addr  = a;
        d_mem_wdata = d;
        d_mem_wen   = w;
        @(negedge clk);
        d_mem_wen = 4'h0;
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        d_mem_addr  = 32'h0;
        d_mem_wdata = 32'h0;
        d_mem_wen   = 4'h0;
        cap_ready   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_valid", 32'(cap_valid), 32'h0);
        chk("rst_ovf", 32'(cap_overflow), 32'h0);
        chk("rst_drop", 32'(cap_dropped), 32'h0);
        chk("rst_index", 32'(cap_index), 32'h0);
        chk("rst_data", cap_data, 32'h0);
        rst_n = 1'b1;

        // Word write, read back, out-of-range read.
        wr(32'h010, 32'hDEADBEEF, 4'hF);
        chk("word_rd", d_mem_rdata, 32'hDEADBEEF);
        d_mem_addr = 32'h1000;
        #1;
        chk("oor_rd", d_mem_rdata, 32'h0);

        // Byte lanes 0 and 2 over a preloaded word.
        wr(32'h020, 32'h11223344, 4'hF);
        wr(32'h020, 32'hAABBCCDD, 4'b0101);
        chk("lane_rd", d_mem_rdata, 32'h11BB33DD);
        chk("no_cap_lo", 32'(cap_valid), 32'h0);

        // Window captures drained immediately.
        cap_ready = 1'b1;
        wr(32'h404, 32'h7, 4'hF);
        chk("cap1_valid", 32'(cap_valid), 32'h1);
        chk("cap1_index", 32'(cap_index), 32'd1);
        chk("cap1_data", cap_data, 32'h7);
        wr(32'h42C, 32'hFFFFFFF9, 4'hF);
        chk("cap2_valid", 32'(cap_valid), 32'h1);
        chk("cap2_index", 32'(cap_index), 32'd11);
        chk("cap2_data", cap_data, 32'hFFFFFFF9);
        @(negedge clk);
        chk("cap2_gone", 32'(cap_valid), 32'h0);
        wr(32'h430, 32'h1234, 4'hF);
        chk("past_win", 32'(cap_valid), 32'h0);
        chk("past_win_rd", d_mem_rdata, 32'h1234);

        // Backpressure: 18 writes into a 16-entry FIFO.
        cap_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr(32'h400 + 32'(4 * (i % 12)), 32'h100 + 32'(i), 4'hF);
        end
        chk("ovf_valid", 32'(cap_valid), 32'h1);
        chk("ovf_flag", 32'(cap_overflow), 32'h1);
        chk("ovf_drop", 32'(cap_dropped), 32'd2);
        chk("ovf_head", cap_data, 32'h100);
        chk("ovf_hidx", 32'(cap_index), 32'd0);

        // Full FIFO: push and pop on one edge.
        @(negedge clk);
        cap_ready   = 1'b1;
        d_mem_addr  = 32'h400;
        d_mem_wdata = 32'h200;
        d_mem_wen   = 4'hF;
        @(negedge clk);
        d_mem_wen = 4'h0;
        cap_ready = 1'b0;
        chk("pp_drop", 32'(cap_dropped), 32'd2);
        chk("pp_head", cap_data, 32'h101);
        chk("pp_hidx", 32'(cap_index), 32'd1);

        // Drain: 15 survivors then the simultaneous push.
        cap_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 32'(cap_valid), 32'h1);
            chk("drain_data", cap_data,
                (i < 15) ? 32'h101 + 32'(i) : 32'h200);
            chk("drain_index", 32'(cap_index),
                (i < 15) ? 32'((i + 1) % 12) : 32'd0);
            @(negedge clk);
        end
        chk("drain_empty", 32'(cap_valid), 32'h0);
        chk("drain_ovf", 32'(cap_overflow), 32'h1);

        // Reset mid-stream with a write held on the reset edge.
        cap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(32'h400 + 32'(4 * i), 32'h300 + 32'(i), 4'hF);
        end
        chk("pre_rst_valid", 32'(cap_valid), 32'h1);
        chk("pre_rst_data", cap_data, 32'h300);
        @(negedge clk);
        rst_n       = 1'b0;
        d_mem_addr  = 32'h404;
        d_mem_wdata = 32'h00000BAD;
        d_mem_wen   = 4'hF;
        @(negedge clk);
        rst_n     = 1'b1;
        d_mem_wen = 4'h0;
        chk("mid_rst_valid", 32'(cap_valid), 32'h0);
        chk("mid_rst_ovf", 32'(cap_overflow), 32'h0);
        chk("mid_rst_drop", 32'(cap_dropped), 32'h0);
        chk("mid_rst_index", 32'(cap_index), 32'h0);
        chk("mid_rst_data", cap_data, 32'h0);
        chk("mid_rst_ram", d_mem_rdata, 32'h301);
        @(negedge clk);
        chk("rst_no_cap", 32'(cap_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_capture_responder.md
Name: dmem_capture_responder

Overview:
- Synthesizable data-memory responder for the CPU's d_mem interface (cpu_top drives d_mem_addr, d_mem_wdata and d_mem_wen; this block returns d_mem_rdata).
- Holds a byte-writable RAM and snoops every write that lands in a configurable result window, e.g. the DFT result words at 0x400.
- Snooped writes are queued in a FIFO and drained over a valid/ready stream toward a host port (UART/debug), replacing bench-side result scraping.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words.
- WIN_BASE, 32'h400, byte address of the first word in the capture window (word-aligned).
- WIN_WORDS, 12, number of words in the capture window.
- FIFO_DEPTH, 16, capture FIFO entries (power of two).
- CNT_W, 16, width of the dropped-write counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- d_mem_addr  in  32  CPU byte address; bits [1:0] ignored
- d_mem_wdata  in  32  CPU write data
- d_mem_wen  in  4  byte-lane write enables; lane k covers bits [8k+7:8k]
- d_mem_rdata  out  32  read data (combinational)
- cap_valid  out  1  capture entry available
- cap_ready  in  1  consumer accepts entry
- cap_index  out  $clog2(WIN_WORDS)  word offset of the entry within the window
- cap_data  out  32  merged word value after the write
- cap_overflow  out  1  sticky: a capture was dropped because the FIFO was full
- cap_dropped  out  CNT_W  count of dropped captures; saturates at all-ones

Behaviour:
- **Address decode**
  - widx = d_mem_addr[31:2].
  - An access is in-range when d_mem_addr < 4*MEM_WORDS.
- **Read path**
  - d_mem_rdata = mem[widx] when in-range, else 32'h0 (never X).
  - Purely combinational, zero-cycle latency, matching the CPU's single-cycle load expectation.
- **Write path**
  - On posedge clk with rst_n=1, any wen!=0 and in-range: each enabled lane k of mem[widx] takes d_mem_wdata lane k; other lanes keep their old value.
  - The result is visible on d_mem_rdata immediately after that edge.
  - Out-of-range writes are ignored.
- **Merged word**: merged = per-lane mux(wen[k] ? wdata : mem[widx]), computed from the pre-edge contents.
- **Capture**
  - Condition: write is in-range, wen!=0, and WIN_BASE <= addr < WIN_BASE+4*WIN_WORDS.
  - A capture pushes {widx - WIN_BASE/4, merged} at the same edge as the RAM write.
  - Capture latency: cap_valid rises the cycle after the write edge when the FIFO was empty.
- **FIFO**
  - Strict FIFO order; show-ahead, so cap_index/cap_data are valid whenever cap_valid=1.
  - Pop occurs on an edge with cap_valid & cap_ready.
  - Outputs hold stable while cap_valid=1 and cap_ready=0.
- **Full, push, no pop**: the entry is dropped, cap_overflow is set (sticky until reset), and cap_dropped increments, saturating at all-ones. The RAM write still happens.
- **Full, push and pop on the same edge**: both occur, nothing is dropped, and occupancy is unchanged.
- **Empty, push and pop on the same edge**: the pop is not possible because cap_valid=0, so only the push happens.
- **Repeated writes to one window word** each produce a separate entry; no coalescing.
- **Reset**
  - Values on reset:
    - FIFO pointers and occupancy = 0
    - cap_valid = 0
    - cap_overflow = 0
    - cap_dropped = 0
    - cap_index / cap_data = 0
  - RAM contents are NOT cleared; the array is initialized only by simulation preload.
  - A reset mid-stream discards all queued entries, and no write or capture occurs on a reset edge.

Decomposition:
- Shared package dmem_pkg:
  - word width (32)
  - lane count (4)
  - capture entry struct {index, data}
  - default window constants for the DFT (0x400, 12 words) and energy (0x500, 12 words) regions
- Sub-module capture_fifo:
  - parameterized synchronous FIFO with show-ahead output
  - ports: push / push_data / full, pop / pop_data / empty
  - owns occupancy and full/empty logic; the top owns the RAM, decode, merge, and overflow counting.

Test Plan:
- Word write then read: wen=1111 writes 0xDEADBEEF to 0x010 -> the next cycle d_mem_rdata=0xDEADBEEF at 0x010. Reading 0x1000 (out of range) -> 0x00000000.
- Byte lanes: preload 0x11223344 at 0x020, write wen=0101 with data 0xAABBCCDD -> the word reads 0x11BB33DD.
- Window capture: write 0x7 to 0x404, then 0xFFFFFFF9 to 0x42C, with cap_ready=1 -> two entries in order: (index 1, 0x7) then (index 11, 0xFFFFFFF9). cap_valid rises one cycle after each write. A write to 0x430 produces no entry.
- Backpressure and overflow: with cap_ready=0, write 18 window words -> 16 queued, cap_overflow=1, cap_dropped=2. Then assert cap_ready for 16 cycles -> the first 16 values drain in order, then cap_valid=0.
- Full with simultaneous push and pop: with the FIFO full, push one window write while popping with cap_ready=1 -> cap_dropped unchanged and occupancy stays at 16.
- Reset mid-stream: 5 entries queued, pulse rst_n=0 for one cycle -> cap_valid=0, counters=0, and RAM word 0x404 still reads its written value.
